// File: rtl/dice_roll_ctrl_if.sv
// -----------------------------------------------------------------------------
// dice_roll_ctrl_if
//
// Groups the push-button input and the face selector outputs of the dice roll
// controller into one bundle.
//
//   btn_n    raw push-button level, asynchronous, 0 = pressed
//   face     current face value (3 bits), fed straight to the decoder 's' input
//   rolling  high while the die is spinning or slowing down
//   settled  one-cycle pulse when a roll has come to rest
//
// Modports:
//   master  drives the button and observes the face (board / testbench side)
//   slave   receives the button and produces the face (controller side)
// -----------------------------------------------------------------------------
interface dice_roll_ctrl_if;
    logic       btn_n;
    logic [2:0] face;
    logic       rolling;
    logic       settled;

    modport master (
        output btn_n,
        input  face,
        input  rolling,
        input  settled
    );

    modport slave (
        input  btn_n,
        output face,
        output rolling,
        output settled
    );
endinterface

// File: rtl/dice_roll_ctrl.sv
// -----------------------------------------------------------------------------
// dice_roll_ctrl
//
// Turns a raw active-low push-button into the 3-bit face selector used by the
// dice decoder. The button is synchronised and debounced; while it is held the
// face spins pseudo-randomly at a fixed cadence, and after release the die
// decelerates through STEPS progressively slower advances before holding the
// final face and pulsing 'settled'.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   bus.btn_n     raw button, asynchronous, 0 = pressed
//   bus.face      current face, FACE_MIN..FACE_MAX (registered)
//   bus.rolling   high while spinning or slowing (registered)
//   bus.settled   one-cycle pulse when a roll completes (registered)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required before the debounced level flips
//   BASE_STEP        cycles between advances while spinning
//   STEPS            number of deceleration advances after release
//   FACE_MIN/MAX     face value range, 5..8 faces inside 0..7
// -----------------------------------------------------------------------------
module dice_roll_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int BASE_STEP       = 120000,
    parameter int STEPS           = 12,
    parameter int FACE_MIN        = 1,
    parameter int FACE_MAX        = 6
) (
    input  logic            clk,
    input  logic            rst,
    dice_roll_ctrl_if.slave bus
);

    localparam int FACE_RANGE = FACE_MAX - FACE_MIN + 1;
    localparam int DB_W       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    // The longest SLOW interval is BASE_STEP*(STEPS+1), so the timer must
    // hold values up to one less than that.
    localparam int TIMER_MAX  = BASE_STEP * (STEPS + 1) - 1;
    localparam int TIMER_W    = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX + 1);
    localparam int K_W        = (STEPS < 2) ? 1 : $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SLOW
    } state_t;

    state_t               state_q, state_d;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic                 btn_db_q, btn_db_d;
    logic                 btn_prev_q, btn_prev_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [2:0]           face_q, face_d;
    logic                 rolling_q, rolling_d;
    logic                 settled_q, settled_d;

    logic                 btn_rise;
    logic                 btn_fall;
    logic                 advance;
    logic                 roll_done;
    logic [TIMER_W-1:0]   spin_end;
    logic [TIMER_W-1:0]   slow_end;
    logic [3:0]           face_sum;
    logic [2:0]           face_next;

    // Two-flop synchroniser on the inverted pin, so the synchronised level
    // reads 1 while the button is pressed.
    always_comb begin
        sync1_d = ~bus.btn_n;
        sync2_d = sync1_q;
    end

    // Debounce: the counter only runs while the synchronised level disagrees
    // with the debounced level. Any agreement clears it, so a glitch shorter
    // than DEBOUNCE_CYCLES can never flip btn_db. On the cycle the count
    // would reach DEBOUNCE_CYCLES the level flips and the counter restarts.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = ~btn_db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Edges of the debounced button are taken against a delayed copy, so the
    // FSM reacts one cycle after btn_db changes.
    always_comb begin
        btn_prev_d = btn_db_q;
        btn_rise   = btn_db_q & ~btn_prev_q;
        btn_fall   = ~btn_db_q & btn_prev_q;
    end

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0 with the
    // feedback entering at bit 15. It free-runs every cycle, so how long the
    // button is held decides which part of the sequence a roll draws from.
    // A non-zero seed keeps it out of the all-zero lock-up state.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Face advance by a random step of 1..4, wrapped back into the face range.
    // Because the range has at least 5 faces and the step is at most 4, the
    // wrapped result is always in range and never equal to the old face.
    always_comb begin
        face_sum = {1'b0, face_q} + {2'b00, lfsr_q[1:0]} + 4'd1;
        if (face_sum > 4'(FACE_MAX)) begin
            face_sum = face_sum - 4'(FACE_RANGE);
        end
        face_next = face_sum[2:0];
    end

    // Terminal timer values: the spin cadence is fixed, while the SLOW
    // interval grows with the deceleration step as BASE_STEP*(k+1).
    always_comb begin
        spin_end = TIMER_W'(BASE_STEP - 1);
        slow_end = TIMER_W'(BASE_STEP * (int'(k_q) + 1) - 1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic, including the interval timer and the
    // deceleration step counter. In SLOW a new press takes priority over an
    // advance due in the same cycle, so a re-press never lets a roll finish.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        k_d       = k_q;
        advance   = 1'b0;
        roll_done = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                k_d     = '0;
                if (btn_rise) begin
                    state_d = SPIN;
                end
            end
            SPIN: begin
                if (btn_fall) begin
                    state_d = SLOW;
                    k_d     = K_W'(1);
                    timer_d = '0;
                end else if (timer_q == spin_end) begin
                    advance = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SLOW: begin
                if (btn_rise) begin
                    state_d = SPIN;
                    timer_d = '0;
                    k_d     = '0;
                end else if (timer_q == slow_end) begin
                    advance = 1'b1;
                    timer_d = '0;
                    if (k_q == K_W'(STEPS)) begin
                        state_d   = IDLE;
                        k_d       = '0;
                        roll_done = 1'b1;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                k_d     = '0;
            end
        endcase
    end

    // FSM output logic. The outputs are registered from the next state, so
    // 'rolling' and 'settled' line up with the cycle in which the new state
    // (and any new face) becomes visible.
    always_comb begin
        face_d    = advance ? face_next : face_q;
        rolling_d = (state_d != IDLE);
        settled_d = roll_done;
    end

    // Datapath and output registers. Reset returns the button to released and
    // clears every timer, so a roll in progress is abandoned completely.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            lfsr_q     <= 16'hACE1;
            timer_q    <= '0;
            k_q        <= '0;
            face_q     <= 3'(FACE_MIN);
            rolling_q  <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_prev_d;
            lfsr_q     <= lfsr_d;
            timer_q    <= timer_d;
            k_q        <= k_d;
            face_q     <= face_d;
            rolling_q  <= rolling_d;
            settled_q  <= settled_d;
        end
    end

    assign bus.face    = face_q;
    assign bus.rolling = rolling_q;
    assign bus.settled = settled_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dice_roll_ctrl
//
// Drives two controllers from one clock and reset: a small 1..6 die with a
// 3-cycle spin cadence and two deceleration steps, and a wide 0..7 die that
// advances every cycle while spinning. Expected faces come from a reference
// LFSR stepped with plain shifts and the wrap-around advance rule; expected
// timing comes from the debounce latency and interval arithmetic.
// -----------------------------------------------------------------------------
module tb_dice_roll_ctrl;

    logic        clk;
    logic        rst;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] ref_lfsr     = 16'hACE1;
    logic [15:0] lfsr_at_edge = 16'hACE1;

    int          prev_face;
    int          spin_cnt;

    dice_roll_ctrl_if bus ();
    dice_roll_ctrl_if bus_w ();

    dice_roll_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BASE_STEP       (3),
        .STEPS           (2),
        .FACE_MIN        (1),
        .FACE_MAX        (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dice_roll_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BASE_STEP       (1),
        .STEPS           (2),
        .FACE_MIN        (0),
        .FACE_MAX        (7)
    ) dut_wide (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, written with integer shifts: new bit 15 is the parity
    // of bits 0,2,3,5 of the old value (taps 16,14,13,11).
    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        logic [15:0] b;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
        return (v >> 1) | (b << 15);
    endfunction

    // Advance rule: step 1..4 from the two low LFSR bits, wrap into range.
    function automatic int adv_face(int cur, logic [15:0] l, int fmin, int fmax);
        int n;
        n = cur + 1 + int'(l % 16'd4);
        if (n > fmax) n = n - (fmax - fmin + 1);
        return n;
    endfunction

    // Model of the free-running LFSR; lfsr_at_edge is the value the design
    // consumed at the most recent rising edge.
    always @(posedge clk) begin
        lfsr_at_edge <= ref_lfsr;
        ref_lfsr     <= rst ? 16'hACE1 : lfsr_next(ref_lfsr);
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] obs, exp;
        rst = 1'b1;
        bus.btn_n = 1'b1;
        bus_w.btn_n = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        obs = {bus.face, bus.rolling, bus.settled};
        exp = {3'd1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_state got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
        obs = {bus_w.face, bus_w.rolling, bus_w.settled};
        exp = {3'd0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_state_wide got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
        for (int c = 1; c <= 50; c++) begin
            cycle();
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'd1, 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL idle_hold cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
        prev_face = 1;
    endtask

    task automatic test_debounce();
        logic [4:0] obs, exp;
        int glen;
        glen = int'($urandom_range(1, 3));
        $display("[TB] glitch of %0d cycles", glen);
        bus.btn_n = 1'b0;
        repeat (glen) cycle();
        bus.btn_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cycle();
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(prev_face), 1'b0, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL glitch cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
        bus.btn_n = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cycle();
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(prev_face), (c == 7), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL press_latency cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
        spin_cnt = 0;
    endtask

    task automatic test_spin();
        logic [4:0] obs, exp;
        int hold, ef;
        hold = 30 + int'($urandom_range(0, 5));
        for (int c = 1; c <= hold; c++) begin
            cycle();
            spin_cnt++;
            ef = (spin_cnt % 3 == 0) ? adv_face(prev_face, lfsr_at_edge, 1, 6) : prev_face;
            prev_face = ef;
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(ef), 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL spin cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
    endtask

    // Release: spin continues until the falling edge is seen 7 cycles later,
    // then advances land 6 and a further 9 cycles on; the last one ends the roll.
    task automatic test_decel();
        logic [4:0] obs, exp;
        int ef;
        bit adv_now;
        bus.btn_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cycle();
            if (c <= 6) begin
                spin_cnt++;
                adv_now = (spin_cnt % 3 == 0);
            end else begin
                adv_now = (c == 13) || (c == 22);
            end
            ef = adv_now ? adv_face(prev_face, lfsr_at_edge, 1, 6) : prev_face;
            prev_face = ef;
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(ef), (c < 22), (c == 22)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL decel cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
    endtask

    // Re-press timed so the new press is recognised on the very cycle the
    // second SLOW advance was due: the press wins and the advance is dropped.
    task automatic test_repress();
        logic [4:0] obs, exp;
        int ef;
        bit adv_now;
        bus.btn_n = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            cycle();
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(prev_face), (c == 7), 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL repress_start cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
        spin_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            cycle();
            spin_cnt++;
            ef = (spin_cnt % 3 == 0) ? adv_face(prev_face, lfsr_at_edge, 1, 6) : prev_face;
            prev_face = ef;
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(ef), 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL repress_spin cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
        end
        bus.btn_n = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            cycle();
            if (c <= 6) begin
                spin_cnt++;
                adv_now = (spin_cnt % 3 == 0);
            end else if (c < 22) begin
                adv_now = (c == 13);
            end else if (c == 22) begin
                spin_cnt = 0;
                adv_now = 1'b0;
            end else begin
                spin_cnt++;
                adv_now = (spin_cnt % 3 == 0);
            end
            ef = adv_now ? adv_face(prev_face, lfsr_at_edge, 1, 6) : prev_face;
            prev_face = ef;
            obs = {bus.face, bus.rolling, bus.settled};
            exp = {3'(ef), 1'b1, 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL repress cycle %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", c, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
            end
            if (c == 15) bus.btn_n = 1'b0;
        end
    endtask

    // Reset while the small die is still spinning.
    task automatic test_reset_mid();
        logic [4:0] obs, exp;
        rst = 1'b1;
        bus.btn_n = 1'b1;
        cycle();
        rst = 1'b0;
        obs = {bus.face, bus.rolling, bus.settled};
        exp = {3'd1, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_mid got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
        cycle();
        obs = {bus.face, bus.rolling, bus.settled};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_after got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
        end
        prev_face = 1;
    endtask

    task automatic test_range();
        logic [4:0] obs, exp;
        logic [7:0] seen;
        int lat, ef, pw;
        bit ok;
        seen = 8'h00;
        ok = 1'b0;
        lat = 21;
        bus_w.btn_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cycle();
            if (bus_w.rolling === 1'b1) begin
                ok = 1'b1;
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat !== 7) begin
            n_fail++;
            $display("[TB] FAIL wide_press_latency got %0d cycles want 7", lat);
        end
        if (ok) begin
            pw = 0;
            for (int i = 1; i <= 1000; i++) begin
                cycle();
                ef = adv_face(pw, lfsr_at_edge, 0, 7);
                pw = ef;
                obs = {bus_w.face, bus_w.rolling, bus_w.settled};
                exp = {3'(ef), 1'b1, 1'b0};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL wide_advance %0d got f/r/s=%0d/%0b/%0b want %0d/%0b/%0b", i, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
                end
                if (!$isunknown(bus_w.face)) seen[bus_w.face] = 1'b1;
            end
            n_checks++;
            if (seen !== 8'hFF) begin
                n_fail++;
                $display("[TB] FAIL wide_coverage got seen=%b want 11111111", seen);
            end
        end
        bus_w.btn_n = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_n = 1'b1;
        bus_w.btn_n = 1'b1;
        $display("[TB] start");
        test_reset();
        test_debounce();
        test_spin();
        test_decel();
        test_repress();
        test_reset_mid();
        test_range();
        repeat (2) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
